// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM controller.
package pwm_pkg;
  localparam int PWM_EDGE   = 0;
  localparam int PWM_CENTER = 1;
  localparam int CNT_W_MIN  = 8;
  localparam int CNT_W_MAX  = 32;
  localparam int NUM_CH_MAX = 16;

  function automatic int duty_lsb(input int ch, input int width);
    return ch * width;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow-loaded duty, range check, compare and sticky flag.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic             p_zero,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] p_new,
  input  logic [CNT_W-1:0] duty,
  input  logic             clear,
  output logic             pwm,
  output logic             status
);
  logic [CNT_W-1:0] d_act;
  logic             over_new;

  assign over_new = (duty > p_new);

  // count never exceeds the active period, so an over-range duty is
  // automatically high for the whole period through the plain compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_act  <= '0;
      pwm    <= 1'b0;
      status <= 1'b0;
    end else begin
      if (load) d_act <= duty;
      pwm    <= enable && !p_zero && (count < d_act);
      status <= (load && over_new) || (status && !clear);
    end
  end
endmodule

// File: rtl/pwm_controller_multi.sv
// Multi-channel PWM with shared edge/centre-aligned timebase, shadowed
// period/duty registers and a maskable sticky out-of-range interrupt.
module pwm_controller_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20,
  parameter int CENTER = PWM_EDGE
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [CNT_W-1:0]        Period,
  input  logic [NUM_CH*CNT_W-1:0] DutyCycle,
  input  logic                    Update,
  input  logic [NUM_CH-1:0]       IntMask,
  input  logic [NUM_CH-1:0]       IntClear,
  output logic [NUM_CH-1:0]       PWM_out,
  output logic [NUM_CH-1:0]       IntStatus,
  output logic                    Interrupt,
  output logic                    PeriodStart,
  output logic [CNT_W-1:0]        count
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] p_act;
  logic [CNT_W-1:0] p_next;
  logic [CNT_W-1:0] count_next;
  logic             dir_down;
  logic             dir_next;
  logic             pending;
  logic             boundary;
  logic             load;
  logic             p_zero;

  assign p_zero = (p_act == '0);

  // A boundary is any cycle where the counter lands on 0: a wrap, or the
  // idle states (disabled or zero period) where loads must not be starved.
  always_comb begin
    count_next = count;
    dir_next   = dir_down;
    boundary   = 1'b0;
    if (!Enable || p_zero) begin
      count_next = '0;
      dir_next   = 1'b0;
      boundary   = 1'b1;
    end else if (CENTER == PWM_CENTER) begin
      if (!dir_down) begin
        if (count >= p_act) begin
          count_next = count - ONE;
          dir_next   = (count != ONE);
        end else begin
          count_next = count + ONE;
        end
      end else begin
        count_next = count - ONE;
        dir_next   = (count != ONE);
      end
      boundary = (count_next == '0);
    end else begin
      if (count >= p_act) begin
        count_next = '0;
        boundary   = 1'b1;
      end else begin
        count_next = count + ONE;
      end
    end
  end

  assign load   = boundary && (pending || Update);
  assign p_next = load ? Period : p_act;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count       <= '0;
      dir_down    <= 1'b0;
      p_act       <= '0;
      pending     <= 1'b0;
      PeriodStart <= 1'b0;
      Interrupt   <= 1'b0;
    end else begin
      count       <= count_next;
      dir_down    <= dir_next;
      p_act       <= p_next;
      pending     <= !load && (pending || Update);
      PeriodStart <= Enable && (count_next == '0) && (p_next != '0);
      Interrupt   <= |(IntStatus & IntMask);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (Clk),
      .rst_n  (Reset),
      .enable (Enable),
      .load   (load),
      .p_zero (p_zero),
      .count  (count),
      .p_new  (Period),
      .duty   (DutyCycle[duty_lsb(i, CNT_W) +: CNT_W]),
      .clear  (IntClear[i]),
      .pwm    (PWM_out[i]),
      .status (IntStatus[i])
    );
  end
endmodule

// File: tb/tb_pwm_controller_multi.sv
// Bench for pwm_controller_multi: edge and centre instances against a
// period-position reference model, plus hand-computed waveform pins.
module tb_pwm_controller_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  period = '0;
  logic [31:0] duty = '0;
  logic        upd = 1'b0;
  logic [3:0]  mask = '0;
  logic [3:0]  clr = '0;

  logic [3:0] pwm_o  [2];
  logic [3:0] stat_o [2];
  logic       int_o  [2];
  logic       ps_o   [2];
  logic [7:0] cnt_o  [2];

  int total = 0;
  int bad = 0;

  int       m_P    [2];
  int       m_D    [2][4];
  bit       m_pend [2];
  bit [3:0] m_stat [2];
  int       m_pos  [2];
  int       e_cnt  [2];
  bit [3:0] e_pwm  [2];
  bit [3:0] e_stat [2];
  bit       e_int  [2];
  bit       e_ps   [2];
  int       hi_acc [4];
  int       ps_acc;

  always #5 clk = ~clk;

  pwm_controller_multi #(.NUM_CH(4), .CNT_W(8), .CENTER(0)) dut_e (
    .Clk(clk), .Reset(rst_n), .Enable(en), .Period(period), .DutyCycle(duty),
    .Update(upd), .IntMask(mask), .IntClear(clr), .PWM_out(pwm_o[0]),
    .IntStatus(stat_o[0]), .Interrupt(int_o[0]), .PeriodStart(ps_o[0]), .count(cnt_o[0]));

  pwm_controller_multi #(.NUM_CH(4), .CNT_W(8), .CENTER(1)) dut_c (
    .Clk(clk), .Reset(rst_n), .Enable(en), .Period(period), .DutyCycle(duty),
    .Update(upd), .IntMask(mask), .IntClear(clr), .PWM_out(pwm_o[1]),
    .IntStatus(stat_o[1]), .Interrupt(int_o[1]), .PeriodStart(ps_o[1]), .count(cnt_o[1]));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counter value from position within the period.
  function automatic int cnt_of(int m, int pos, int p);
    if (m == 0) return pos;
    return (pos <= p) ? pos : 2 * p - pos;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_P[m] = 0; m_pend[m] = 0; m_stat[m] = '0; m_pos[m] = 0;
      for (int i = 0; i < 4; i++) m_D[m][i] = 0;
      e_cnt[m] = 0; e_pwm[m] = '0; e_stat[m] = '0; e_int[m] = 0; e_ps[m] = 0;
    end
  endtask

  task automatic model_step(int m);
    int p_old, c_old, np, len;
    bit bnd, ld;
    bit [3:0] over;
    p_old = m_P[m];
    c_old = cnt_of(m, m_pos[m], p_old);
    e_int[m] = |(m_stat[m] & mask);
    for (int i = 0; i < 4; i++) e_pwm[m][i] = en && (p_old != 0) && (c_old < m_D[m][i]);
    if (!en || p_old == 0) begin
      np = 0; bnd = 1;
    end else begin
      len = (m == 1) ? 2 * p_old : p_old + 1;
      np = (m_pos[m] + 1) % len;
      bnd = (np == 0);
    end
    ld = bnd && (m_pend[m] || upd);
    for (int i = 0; i < 4; i++) over[i] = int'(duty[i*8 +: 8]) > int'(period);
    m_stat[m] = (m_stat[m] & ~clr) | (ld ? over : 4'b0);
    if (ld) begin
      m_P[m] = int'(period);
      for (int i = 0; i < 4; i++) m_D[m][i] = int'(duty[i*8 +: 8]);
    end
    m_pend[m] = !ld && (m_pend[m] || upd);
    m_pos[m] = np;
    e_stat[m] = m_stat[m];
    e_ps[m] = en && (np == 0) && (m_P[m] != 0);
    e_cnt[m] = cnt_of(m, np, m_P[m]);
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    else for (int m = 0; m < 2; m++) model_step(m);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("count[%0d]", m), cnt_o[m], e_cnt[m]);
      check($sformatf("pwm[%0d]", m), pwm_o[m], e_pwm[m]);
      check($sformatf("status[%0d]", m), stat_o[m], e_stat[m]);
      check($sformatf("irq[%0d]", m), int_o[m], e_int[m]);
      check($sformatf("pstart[%0d]", m), ps_o[m], e_ps[m]);
    end
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic measure(int m, int n);
    for (int i = 0; i < 4; i++) hi_acc[i] = 0;
    ps_acc = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      for (int i = 0; i < 4; i++) hi_acc[i] += int'(pwm_o[m][i]);
      ps_acc += int'(ps_o[m]);
    end
  endtask

  task automatic pulse_update();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  initial begin
    int k;
    model_reset();
    #2;
    check("rst_count", cnt_o[0], 0);
    check("rst_pwm", {pwm_o[0], pwm_o[1]}, 0);
    check("rst_flags", {stat_o[0], int_o[0], ps_o[0], stat_o[1]}, 0);
    run(2);
    rst_n = 1'b1;
    run(2);

    // edge: P=9, duties 0,3,9,10
    en = 1'b1; period = 8'd9; duty = {8'd10, 8'd9, 8'd3, 8'd0};
    pulse_update();
    run(25);
    measure(0, 10);
    check("edge_hi0", hi_acc[0], 0);
    check("edge_hi1", hi_acc[1], 3);
    check("edge_hi2", hi_acc[2], 9);
    check("edge_hi3", hi_acc[3], 10);
    check("edge_ps_per_period", ps_acc, 1);
    check("edge_status", stat_o[0], 4'b1000);

    // centre: P=8, duty 4 -> 16-cycle period
    period = 8'd8; duty = {8'd9, 8'd8, 8'd0, 8'd4};
    pulse_update();
    run(45);
    measure(1, 16);
    check("ctr_hi0", hi_acc[0], 7);
    check("ctr_hi2", hi_acc[2], 15);
    check("ctr_hi3", hi_acc[3], 16);
    check("ctr_ps_per_period", ps_acc, 1);
    measure(0, 9);
    check("edge8_hi0", hi_acc[0], 4);

    // interrupt mask and clear-vs-set collision
    mask = 4'b1000;
    run(2);
    check("irq_on_e", int_o[0], 1);
    check("irq_on_c", int_o[1], 1);
    en = 1'b0;
    tick();
    duty = {8'd10, 8'd8, 8'd0, 8'd4};
    upd = 1'b1; clr = 4'b1000;
    tick();
    upd = 1'b0; clr = 4'b0;
    check("set_wins", stat_o[0][3], 1);
    clr = 4'b1000;
    tick();
    clr = 4'b0;
    check("cleared", stat_o[0], 0);
    tick();
    check("irq_off", int_o[0], 0);

    // mid-period duty change 3 -> 6 at count 5
    en = 1'b1; period = 8'd9; duty = {8'd0, 8'd0, 8'd3, 8'd0};
    pulse_update();
    run(15);
    k = 0;
    while (e_cnt[0] != 5 && k < 50) begin tick(); k++; end
    check("reach_cnt5", k < 50, 1);
    duty = {8'd0, 8'd0, 8'd6, 8'd0};
    pulse_update();
    run(30);
    measure(0, 10);
    check("new_duty_hi1", hi_acc[1], 6);

    // enable drop mid-period, then resume with retained duty
    run(4);
    en = 1'b0;
    tick();
    check("dis_count", cnt_o[0], 0);
    check("dis_pwm", pwm_o[0], 0);
    run(3);
    en = 1'b1;
    run(25);
    measure(0, 10);
    check("resume_hi1", hi_acc[1], 6);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) period = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 9) == 0)
        for (int i = 0; i < 4; i++) duty[i*8 +: 8] = 8'($urandom_range(0, 22));
      upd = ($urandom_range(0, 19) == 0);
      mask = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      tick();
    end
    upd = 1'b0; clr = 4'b0;

    // asynchronous reset mid-period
    en = 1'b1; period = 8'd9; duty = {8'd10, 8'd9, 8'd3, 8'd5};
    pulse_update();
    run(16);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", {cnt_o[0], cnt_o[1]}, 0);
    check("arst_pwm", {pwm_o[0], pwm_o[1]}, 0);
    check("arst_flags", {stat_o[0], stat_o[1], int_o[0], int_o[1], ps_o[0], ps_o[1]}, 0);
    model_reset();
    run(2);
    rst_n = 1'b1;
    run(30);
    check("post_rst_pwm", {pwm_o[0], pwm_o[1]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
